// File: rtl/bbpd_vote.sv
// Bang-bang (Alexander) phase detector with a majority vote over VOTE_WORDS words.
// Emits a one-cycle phe strobe per window: 01 advance, 11 retard, 00 no decision.
module bbpd_vote #(
    parameter int WIDTH      = 10,
    parameter int VOTE_WORDS = 4,
    parameter int THRESH     = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_s,
    input  logic [WIDTH-1:0] edge_s,
    output logic [1:0]       phe,
    output logic             phe_valid
);

    localparam int PW = $clog2(WIDTH + 1);
    localparam int AW = $clog2(VOTE_WORDS * WIDTH + 1);
    localparam int CW = (VOTE_WORDS > 1) ? $clog2(VOTE_WORDS) : 1;

    logic             prev_ok;
    logic             prev_bit;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] trans;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] up_f;
    logic [WIDTH-1:0] dn_f;
    logic [PW-1:0]    up_cnt;
    logic [PW-1:0]    dn_cnt;

    logic             s1_valid;
    logic [PW-1:0]    up_pop;
    logic [PW-1:0]    dn_pop;

    logic [AW-1:0]    up_acc;
    logic [AW-1:0]    dn_acc;
    logic [CW-1:0]    word_cnt;
    logic [AW-1:0]    up_sum;
    logic [AW-1:0]    dn_sum;
    logic signed [AW:0] diff;
    int               diff_x;
    logic             last;
    logic [1:0]       phe_n;

    // Bit 0 compares against the last bit of the previous accepted word.
    always_comb begin
        d0    = {data_s[WIDTH-2:0], prev_bit};
        trans = d0 ^ data_s;
        mask  = {{(WIDTH-1){1'b1}}, prev_ok};
        up_f  = trans & ~(edge_s ^ d0) & mask;
        dn_f  = trans & ~(edge_s ^ data_s) & mask;
    end

    always_comb begin
        up_cnt = '0;
        dn_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_cnt = up_cnt + PW'(up_f[i]);
            dn_cnt = dn_cnt + PW'(dn_f[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_ok  <= 1'b0;
            prev_bit <= 1'b0;
        end else if (in_valid) begin
            prev_ok  <= 1'b1;
            prev_bit <= data_s[WIDTH-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            up_pop   <= '0;
            dn_pop   <= '0;
        end else begin
            s1_valid <= in_valid;
            up_pop   <= up_cnt;
            dn_pop   <= dn_cnt;
        end
    end

    always_comb begin
        up_sum = up_acc + AW'(up_pop);
        dn_sum = dn_acc + AW'(dn_pop);
        diff   = $signed({1'b0, up_sum}) - $signed({1'b0, dn_sum});
        diff_x = int'(diff);
        last   = s1_valid && (word_cnt == CW'(VOTE_WORDS - 1));
        phe_n  = 2'b00;
        if (diff_x > THRESH) begin
            phe_n = 2'b01;
        end else if (diff_x < -THRESH) begin
            phe_n = 2'b11;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            up_acc    <= '0;
            dn_acc    <= '0;
            word_cnt  <= '0;
            phe       <= 2'b00;
            phe_valid <= 1'b0;
        end else begin
            phe       <= 2'b00;
            phe_valid <= 1'b0;
            if (last) begin
                up_acc    <= '0;
                dn_acc    <= '0;
                word_cnt  <= '0;
                phe       <= phe_n;
                phe_valid <= 1'b1;
            end else if (s1_valid) begin
                up_acc    <= up_sum;
                dn_acc    <= dn_sum;
                word_cnt  <= word_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bbpd_vote.sv
// Directed bench for bbpd_vote; a second instance runs with THRESH=25.
module tb_bbpd_vote;

    logic       CLK = 1'b0;
    logic       RST;
    logic       in_valid;
    logic [9:0] data_s;
    logic [9:0] edge_s;
    logic [1:0] phe;
    logic       phe_valid;
    logic [1:0] phe_b;
    logic       phe_valid_b;

    int total  = 0;
    int passed = 0;

    localparam logic [9:0] ALT  = 10'b0101010101;
    localparam logic [9:0] NALT = 10'b1010101010;

    always #5 CLK = ~CLK;

    bbpd_vote #(.WIDTH(10), .VOTE_WORDS(4), .THRESH(0)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .data_s    (data_s),
        .edge_s    (edge_s),
        .phe       (phe),
        .phe_valid (phe_valid)
    );

    bbpd_vote #(.WIDTH(10), .VOTE_WORDS(4), .THRESH(25)) dut_t (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .data_s    (data_s),
        .edge_s    (edge_s),
        .phe       (phe_b),
        .phe_valid (phe_valid_b)
    );

    task automatic cyc(input logic v, input logic [9:0] d, input logic [9:0] e);
        in_valid = v;
        data_s   = d;
        edge_s   = e;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 10'h000, 10'h000);
    endtask

    task automatic chk(input string tag, input logic [1:0] ep, input logic ev);
        total++;
        assert ({phe, phe_valid} === {ep, ev}) passed++;
        else $error("FAIL %s: phe=%b valid=%b, expected phe=%b valid=%b",
                    tag, phe, phe_valid, ep, ev);
    endtask

    task automatic chk_t(input string tag, input logic [1:0] ep, input logic ev);
        total++;
        assert ({phe_b, phe_valid_b} === {ep, ev}) passed++;
        else $error("FAIL %s: phe=%b valid=%b, expected phe=%b valid=%b",
                    tag, phe_b, phe_valid_b, ep, ev);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle();
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        RST      = 1'b1;
        in_valid = 1'b0;
        data_s   = '0;
        edge_s   = '0;

        // 1: reset with valid random words, then release
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 10'($urandom), 10'($urandom));
            chk("reset_hold", 2'b00, 1'b0);
        end
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("reset_release", 2'b00, 1'b0);
        end

        // 2: late clock, dn=39
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, ALT, ALT);
            chk("late_word", 2'b00, 1'b0);
        end
        idle();
        chk("late_strobe", 2'b11, 1'b1);
        idle();
        chk("late_after", 2'b00, 1'b0);

        // 3: early clock, streaming two windows back to back
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, ALT, NALT);
            if (k == 5) chk("early_strobe1", 2'b01, 1'b1);
            else        chk("early_word", 2'b00, 1'b0);
        end
        idle();
        chk("early_strobe2", 2'b01, 1'b1);
        idle();
        chk("early_after", 2'b00, 1'b0);

        // 4: no transitions
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 10'h000, 10'($urandom));
            chk("flat_word", 2'b00, 1'b0);
        end
        idle();
        chk("flat_strobe", 2'b00, 1'b1);

        // 5: mixed votes, dn=9 up=30 (diff 21), then 20 vs 20
        do_reset();
        cyc(1'b1, ALT, ALT);
        for (int k = 0; k < 3; k++) cyc(1'b1, ALT, NALT);
        idle();
        chk("mixed_up", 2'b01, 1'b1);
        chk_t("mixed_thresh25", 2'b00, 1'b1);
        cyc(1'b1, ALT, ALT);
        cyc(1'b1, ALT, ALT);
        cyc(1'b1, ALT, NALT);
        cyc(1'b1, ALT, NALT);
        idle();
        chk("mixed_tie", 2'b00, 1'b1);
        chk_t("mixed_tie_thresh25", 2'b00, 1'b1);

        // 6a: late words separated by idle gaps
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, ALT, ALT);
            chk("gap_word", 2'b00, 1'b0);
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    idle();
                    chk("gap_idle", 2'b00, 1'b0);
                end
            end
        end
        idle();
        chk("gap_strobe", 2'b11, 1'b1);
        chk_t("gap_strobe_thresh25", 2'b11, 1'b1);
        idle();
        chk("gap_after", 2'b00, 1'b0);

        // 6b: reset mid-window discards the partial window
        cyc(1'b1, ALT, NALT);
        cyc(1'b1, ALT, NALT);
        do_reset();
        chk("midrst", 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, ALT, ALT);
            chk("midrst_word", 2'b00, 1'b0);
        end
        idle();
        chk("midrst_strobe", 2'b11, 1'b1);
        idle();
        chk("midrst_after", 2'b00, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
